spi_slave_rx: RTL and testbench

//  Receive-side SPI slave: the far end of the DAC link driven by the SPI master.

---
 rtl/spi_slave_rx_pkg.sv | 14 +
 rtl/spi_slave_rx_if.sv | 23 ++
 rtl/spi_slave_rx_sync_edge.sv | 23 ++
 rtl/spi_slave_rx.sv | 111 +++++++++++
 tb/tb_spi_slave_rx.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_rx_pkg.sv
// spi_slave_rx_pkg: shared FSM states, SPI mode constants and sample-edge selection for spi_slave_rx
package spi_slave_rx_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;
  localparam logic [1:0] EDGE_RISE = 2'b10;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  // Leading edge is rising for CPOL=0, so sampling is on the rising pin edge whenever CPOL==CPHA.
  function automatic logic [1:0] sample_edge(input logic cpol, input logic cpha);
    return (cpol ^ cpha) ? EDGE_FALL : EDGE_RISE;
  endfunction
endpackage

// File: rtl/spi_slave_rx_if.sv
// spi_slave_rx_if: SPI pins, LDAC strobe and received-word outputs of spi_slave_rx
// i_spi_cs/i_spi_sclk/i_spi_sdi/i_ldac: asynchronous pins into the slave
// o_data/o_valid/o_frame_err/o_busy: received word, update pulse, error pulse, frame in progress
interface spi_slave_rx_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  i_spi_cs;
  logic                  i_spi_sclk;
  logic                  i_spi_sdi;
  logic                  i_ldac;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  o_frame_err;
  logic                  o_busy;
  modport slave (
    input  i_spi_cs, i_spi_sclk, i_spi_sdi, i_ldac,
    output o_data, o_valid, o_frame_err, o_busy
  );
  modport master (
    output i_spi_cs, i_spi_sclk, i_spi_sdi, i_ldac,
    input  o_data, o_valid, o_frame_err, o_busy
  );
endinterface

// File: rtl/spi_slave_rx_sync_edge.sv
// spi_slave_rx_sync_edge: multi-stage input synchroniser with registered rise/fall detection
// i_clk, i_rst (sync, active high, loads IDLE); i_d async pin; o_edge = {rise, fall}, one cycle each
module spi_slave_rx_sync_edge #(
  parameter int STAGES = 2,
  parameter bit IDLE   = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_d,
  output logic [1:0] o_edge
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_sync <= {STAGES{IDLE}};
      r_prev <= IDLE;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  assign o_edge = {r_sync[STAGES-1] & ~r_prev, ~r_sync[STAGES-1] & r_prev};
endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampling SPI slave receiver for fixed-length MSB-first frames
// i_clk, i_rst (sync, active high); bus (spi_slave_rx_if.slave): CS/SCLK/SDI/LDAC in, data/valid/frame_err/busy out
// Macro SPI_RX_LDAC_EN: accepted words wait in a pending register until a synced i_ldac fall
module spi_slave_rx
  import spi_slave_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input logic           i_clk,
  input logic           i_rst,
  spi_slave_rx_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);
  localparam logic [1:0] SAMPLE = sample_edge(CPOL, CPHA);
  state_t                  r_state, w_next;
  logic [1:0]              w_cs_edge, w_sclk_edge;
  logic [SYNC_STAGES-1:0]  r_sdi;
  logic [DATA_WIDTH-1:0]   r_shift, r_data;
  logic [CW-1:0]           r_cnt;
  logic                    r_ovr, r_good, r_late, r_valid, r_err;
  logic                    w_cs_fall, w_cs_rise, w_sample, w_start, w_accept;
  spi_slave_rx_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_cs (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(bus.i_spi_cs), .o_edge(w_cs_edge)
  );
  spi_slave_rx_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(CPOL)) u_sclk (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(bus.i_spi_sclk), .o_edge(w_sclk_edge)
  );
  // SDI gets the same depth as SCLK so the sampled bit lines up with the detected edge.
  always_ff @(posedge i_clk)
    if (i_rst) r_sdi <= '0;
    else r_sdi <= {r_sdi[SYNC_STAGES-2:0], bus.i_spi_sdi};
  assign w_cs_fall = w_cs_edge == EDGE_FALL;
  assign w_cs_rise = w_cs_edge == EDGE_RISE;
  assign w_sample  = w_sclk_edge == SAMPLE;
  always_ff @(posedge i_clk)
    if (i_rst) r_state <= ST_IDLE;
    else r_state <= w_next;
  // r_late holds a CS fall seen during DONE so IDLE can still start that frame.
  // A CS low period with no sampled bits is treated as a glitch, not a frame.
  always_comb begin
    w_next = r_state;
    w_next = r_state == ST_IDLE  ? ((w_cs_fall || r_late) ? ST_SHIFT : ST_IDLE) :
             r_state == ST_SHIFT ? (w_cs_rise ? (r_cnt == '0 ? ST_IDLE : ST_DONE) : ST_SHIFT) :
                                   ST_IDLE;
  end
  assign w_start  = r_state == ST_IDLE && w_next == ST_SHIFT;
  assign w_accept = r_state == ST_DONE && r_good;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_ovr   <= 1'b0;
      r_good  <= 1'b0;
      r_late  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_late <= r_state == ST_DONE && w_cs_fall;
      r_err  <= r_state == ST_DONE && !r_good;
      if (r_state == ST_SHIFT && w_cs_rise) r_good <= r_cnt == FULL && !r_ovr;
      if (w_start) begin
        r_shift <= '0;
        r_cnt   <= '0;
        r_ovr   <= 1'b0;
      end else if (r_state == ST_SHIFT && !w_cs_rise && w_sample) begin
        if (r_cnt == FULL) r_ovr <= 1'b1;
        else begin
          r_shift <= {r_shift[DATA_WIDTH-2:0], r_sdi[SYNC_STAGES-1]};
          r_cnt   <= r_cnt + CW'(1);
        end
      end
    end
`ifdef SPI_RX_LDAC_EN
  logic [1:0]            w_ldac_edge;
  logic [DATA_WIDTH-1:0] r_pend_data;
  logic                  r_pend, w_load;
  spi_slave_rx_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_ldac (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(bus.i_ldac), .o_edge(w_ldac_edge)
  );
  assign w_load = w_ldac_edge == EDGE_FALL && r_pend;
  // On a same-cycle load and accept, the old pending word moves out while the new one takes its place.
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_pend      <= 1'b0;
      r_pend_data <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= w_load;
      if (w_load) r_data <= r_pend_data;
      if (w_accept) r_pend_data <= r_shift;
      r_pend <= w_accept || (r_pend && !w_load);
    end
`else
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) r_data <= r_shift;
    end
`endif
  assign bus.o_data      = r_data;
  assign bus.o_valid     = r_valid;
  assign bus.o_frame_err = r_err;
  assign bus.o_busy      = r_state == ST_SHIFT;
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed plus randomized frames on mode-0 and mode-3 receivers against a frame-level model
module tb_spi_slave_rx;
  localparam int W  = 16;
  localparam int SS = 2;
`ifdef SPI_RX_LDAC_EN
  localparam bit LDAC = 1'b1;
`else
  localparam bit LDAC = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs0 = 1'b1, sclk0 = 1'b0, sdi0 = 1'b0;
  logic cs3 = 1'b1, sclk3 = 1'b1, sdi3 = 1'b0;
  logic ldac = 1'b1;
  int checks = 0;
  int errors = 0;
  int nv[2], ne[2], env[2], ene[2];
  logic [W-1:0] exp_data[2], pend_data[2];
  bit pend[2];
  spi_slave_rx_if #(.DATA_WIDTH(W)) b0 ();
  spi_slave_rx_if #(.DATA_WIDTH(W)) b3 ();
  assign b0.i_spi_cs   = cs0;
  assign b0.i_spi_sclk = sclk0;
  assign b0.i_spi_sdi  = sdi0;
  assign b0.i_ldac     = ldac;
  assign b3.i_spi_cs   = cs3;
  assign b3.i_spi_sclk = sclk3;
  assign b3.i_spi_sdi  = sdi3;
  assign b3.i_ldac     = ldac;
  spi_slave_rx #(.DATA_WIDTH(W), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(SS)) dut0 (
    .i_clk(clk), .i_rst(rst), .bus(b0)
  );
  spi_slave_rx #(.DATA_WIDTH(W), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(SS)) dut3 (
    .i_clk(clk), .i_rst(rst), .bus(b3)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (b0.o_valid) nv[0]++;
    if (b0.o_frame_err) ne[0]++;
    if (b3.o_valid) nv[1]++;
    if (b3.o_frame_err) ne[1]++;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [W-1:0] odata(input int d);
    return d == 1 ? b3.o_data : b0.o_data;
  endfunction
  function automatic logic obusy(input int d);
    return d == 1 ? b3.o_busy : b0.o_busy;
  endfunction
  function automatic logic opulse(input int d);
    return d == 1 ? (b3.o_valid | b3.o_frame_err) : (b0.o_valid | b0.o_frame_err);
  endfunction
  task automatic pins(input int d, input logic c, input logic s, input logic x);
    if (d == 1) begin
      cs3 = c; sclk3 = s; sdi3 = x;
    end else begin
      cs0 = c; sclk0 = s; sdi0 = x;
    end
  endtask
  task automatic check_state(input int d, input string tag);
    check({tag, "_data"}, 32'(odata(d)), 32'(exp_data[d]));
    check({tag, "_nvalid"}, nv[d], env[d]);
    check({tag, "_nerr"}, ne[d], ene[d]);
  endtask
  // Sends nbits of word MSB-first; d=0 drives the mode-0 slave, d=1 the mode-3 slave.
  // rst_at >= 0 asserts reset once that many bits have gone out and abandons the frame.
  task automatic send(input int d, input logic [31:0] word, input int nbits, input int rst_at);
    bit q[$];
    logic [31:0] v;
    logic idle;
    int lat;
    idle = (d == 1);
    for (int i = nbits - 1; i >= 0; i--) q.push_back(word[i]);
    pins(d, 1'b0, idle, 1'b0);
    tick(5);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        pins(d, 1'b1, idle, 1'b0);
        tick(3);
        rst = 1'b0;
        tick(6);
        for (int k = 0; k < 2; k++) begin
          exp_data[k] = '0;
          pend[k] = 1'b0;
        end
        check("rst_busy", 32'(obusy(d)), 32'd0);
        check_state(d, "rst");
        return;
      end
      pins(d, 1'b0, 1'b0, q[i]);
      tick(5);
      pins(d, 1'b0, 1'b1, q[i]);
      tick(5);
      if (d == 0) pins(d, 1'b0, 1'b0, q[i]);
      if (i == 1) check("busy", 32'(obusy(d)), 32'd1);
    end
    tick(5);
    pins(d, 1'b1, idle, 1'b0);
    v = '0;
    foreach (q[k]) v = (v << 1) | 32'(q[k]);
    if (q.size() != W) ene[d]++;
    else if (LDAC) begin
      pend[d] = 1'b1;
      pend_data[d] = v[W-1:0];
    end else begin
      exp_data[d] = v[W-1:0];
      env[d]++;
    end
    if (q.size() != W || !LDAC) begin
      lat = 0;
      do begin
        tick(1);
        lat++;
      end while (!opulse(d) && lat < 20);
      check("latency", lat, SS + 2);
    end
    tick(8);
    check_state(d, "frame");
  endtask
  task automatic ldac_pulse();
    ldac = 1'b0;
    tick(4);
    ldac = 1'b1;
    tick(6);
    for (int k = 0; k < 2; k++)
      if (pend[k]) begin
        exp_data[k] = pend_data[k];
        env[k]++;
        pend[k] = 1'b0;
      end
    check_state(0, "ldac0");
    check_state(1, "ldac3");
  endtask
  initial begin
    int r;
    for (int k = 0; k < 2; k++) begin
      exp_data[k] = '0;
      pend_data[k] = '0;
    end
    tick(4);
    check("rst_data0", 32'(b0.o_data), 32'd0);
    check("rst_valid0", 32'(b0.o_valid), 32'd0);
    check("rst_err0", 32'(b0.o_frame_err), 32'd0);
    check("rst_busy0", 32'(b0.o_busy), 32'd0);
    check("rst_data3", 32'(b3.o_data), 32'd0);
    check("rst_busy3", 32'(b3.o_busy), 32'd0);
    rst = 1'b0;
    tick(4);
    send(0, 32'hA55A, 16, -1);
    send(0, 32'h7FFF, 15, -1);
    send(0, 32'h1ABCD, 17, -1);
    send(0, 32'h1234, 16, -1);
    send(0, 32'hDEAD, 16, 8);
    send(0, 32'hBEEF, 16, -1);
    send(1, 32'h8001, 16, -1);
    for (int i = 0; i < 8; i++) begin
      sclk3 = ~sclk3;
      sdi3 = ~sdi3;
      tick(5);
    end
    check("idle_sclk_busy", 32'(b3.o_busy), 32'd0);
    check_state(1, "idle_sclk");
    send(0, 32'h00FF, 16, -1);
    ldac_pulse();
    send(0, 32'h1111, 16, -1);
    send(0, 32'h2222, 16, -1);
    ldac_pulse();
    ldac_pulse();
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 5);
      send(n % 4 == 3 ? 1 : 0, $urandom, r == 0 ? 15 : (r == 1 ? 17 : 16), -1);
      if ($urandom_range(0, 2) == 0) ldac_pulse();
    end
    ldac_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
